// File: rtl/lsu_dmem_responder_pkg.sv
// Shared types and defaults for the LSU data-memory responder and its bit-masked array.
package lsu_dmem_responder_pkg;

   localparam int unsigned DWORD_WIDTH        = 64;
   localparam int unsigned INDEX_WIDTH        = 64;
   localparam int unsigned DEFAULT_DEPTH_LOG2 = 12;
   localparam int unsigned DEFAULT_LATENCY    = 2;
   localparam int unsigned CNT_WIDTH          = 4;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   function automatic logic [DWORD_WIDTH-1:0] merge_masked(
      input logic [DWORD_WIDTH-1:0] old_word,
      input logic [DWORD_WIDTH-1:0] new_word,
      input logic [DWORD_WIDTH-1:0] mask
   );
      return (old_word & ~mask) | (new_word & mask);
   endfunction

endpackage

// File: rtl/dmem_sram_bitmask.sv
// Single-port 64-bit array with registered read data and per-bit masked writes.
module dmem_sram_bitmask
   import lsu_dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_DEPTH_LOG2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   write_enable,
   input  logic [ADDR_WIDTH-1:0]  address,
   input  logic [DWORD_WIDTH-1:0] write_data,
   input  logic [DWORD_WIDTH-1:0] write_mask,
   output logic [DWORD_WIDTH-1:0] read_data
);

   logic [DWORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Array contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (enable && write_enable) begin
         mem[address] <= merge_masked(mem[address], write_data, write_mask);
      end
   end

   // Read data only moves on a read, so it holds across writes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_data <= '0;
      end else if (enable && !write_enable) begin
         read_data <= mem[address];
      end
   end

endmodule

// File: rtl/lsu_dmem_responder.sv
// Memory-side responder for the opload/opstore request channels: one request at a time,
// fixed access latency, bit-masked stores into a local array.
module lsu_dmem_responder
   import lsu_dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int unsigned LATENCY    = DEFAULT_LATENCY
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   opload_index_valid,
   output logic                   opload_index_ready,
   input  logic [INDEX_WIDTH-1:0] opload_index,
   output logic                   opload_operation_done,
   output logic [DWORD_WIDTH-1:0] opload_read_data,
   input  logic                   opstore_index_valid,
   output logic                   opstore_index_ready,
   input  logic [INDEX_WIDTH-1:0] opstore_index,
   input  logic [DWORD_WIDTH-1:0] opstore_write_data,
   input  logic [DWORD_WIDTH-1:0] opstore_write_mask,
   output logic                   opstore_operation_done
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LATENCY - 1);

   state_e                 state_q;
   logic                   idle_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   is_load_q;
   logic [DEPTH_LOG2-1:0]  idx_q;
   logic [DWORD_WIDTH-1:0] data_q;
   logic [DWORD_WIDTH-1:0] mask_q;
   logic                   load_done_q;
   logic                   store_done_q;

   logic                   load_fire;
   logic                   store_fire;
   logic                   any_fire;
   logic                   last_beat;
   logic                   sram_en;
   logic                   sram_we;
   logic [DEPTH_LOG2-1:0]  sram_addr;
   logic                   unused_index_bits;

   // idle_q is registered so both readies stay low while reset is asserted.
   assign opload_index_ready  = idle_q;
   assign opstore_index_ready = idle_q & ~opload_index_valid;

   assign load_fire  = opload_index_valid & opload_index_ready;
   assign store_fire = opstore_index_valid & opstore_index_ready;
   assign any_fire   = load_fire | store_fire;
   assign last_beat  = (state_q == StBusy) && (cnt_q == CNT_LAST);

   assign opload_operation_done  = load_done_q;
   assign opstore_operation_done = store_done_q;

   // Upper index bits are dropped; addresses wrap modulo the array depth.
   assign unused_index_bits = ^{opload_index[INDEX_WIDTH-1:DEPTH_LOG2],
                                opstore_index[INDEX_WIDTH-1:DEPTH_LOG2]};

   // Loads read in the cycle before DONE; stores commit during DONE.
   always_comb begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = idx_q;
      if (LATENCY == 1 && load_fire) begin
         sram_en   = 1'b1;
         sram_addr = opload_index[DEPTH_LOG2-1:0];
      end else if (last_beat && is_load_q) begin
         sram_en = 1'b1;
      end else if (state_q == StDone && !is_load_q) begin
         sram_en = 1'b1;
         sram_we = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         idle_q       <= 1'b0;
         cnt_q        <= '0;
         is_load_q    <= 1'b0;
         idx_q        <= '0;
         data_q       <= '0;
         mask_q       <= '0;
         load_done_q  <= 1'b0;
         store_done_q <= 1'b0;
      end else begin
         load_done_q  <= 1'b0;
         store_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_fire) begin
                  idle_q    <= 1'b0;
                  is_load_q <= load_fire;
                  idx_q     <= load_fire ? opload_index[DEPTH_LOG2-1:0]
                                         : opstore_index[DEPTH_LOG2-1:0];
                  data_q    <= opstore_write_data;
                  mask_q    <= opstore_write_mask;
                  if (LATENCY == 1) begin
                     state_q      <= StDone;
                     load_done_q  <= load_fire;
                     store_done_q <= store_fire;
                  end else begin
                     state_q <= StBusy;
                     cnt_q   <= CNT_WIDTH'(1);
                  end
               end else begin
                  idle_q <= 1'b1;
               end
            end
            StBusy: begin
               if (cnt_q == CNT_LAST) begin
                  state_q      <= StDone;
                  load_done_q  <= is_load_q;
                  store_done_q <= ~is_load_q;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               idle_q  <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
               idle_q  <= 1'b0;
            end
         endcase
      end
   end

   dmem_sram_bitmask #(
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_sram (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (sram_en),
      .write_enable (sram_we),
      .address      (sram_addr),
      .write_data   (data_q),
      .write_mask   (mask_q),
      .read_data    (opload_read_data)
   );

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Scoreboard bench for lsu_dmem_responder: directed cases plus randomized load/store traffic.
module tb_lsu_dmem_responder;

   localparam int unsigned DL  = 12;
   localparam int unsigned LAT = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        opload_index_valid = 1'b0;
   logic        opload_index_ready;
   logic [63:0] opload_index = '0;
   logic        opload_operation_done;
   logic [63:0] opload_read_data;
   logic        opstore_index_valid = 1'b0;
   logic        opstore_index_ready;
   logic [63:0] opstore_index = '0;
   logic [63:0] opstore_write_data = '0;
   logic [63:0] opstore_write_mask = '0;
   logic        opstore_operation_done;

   lsu_dmem_responder #(
      .DEPTH_LOG2 (DL),
      .LATENCY    (LAT)
   ) dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .opload_index_valid     (opload_index_valid),
      .opload_index_ready     (opload_index_ready),
      .opload_index           (opload_index),
      .opload_operation_done  (opload_operation_done),
      .opload_read_data       (opload_read_data),
      .opstore_index_valid    (opstore_index_valid),
      .opstore_index_ready    (opstore_index_ready),
      .opstore_index          (opstore_index),
      .opstore_write_data     (opstore_write_data),
      .opstore_write_mask     (opstore_write_mask),
      .opstore_operation_done (opstore_operation_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          ld;
      logic [63:0] idx;
      logic [63:0] data;
      logic [63:0] mask;
      int          cyc;
   } req_t;

   req_t        q[$];
   logic [63:0] mdl [int unsigned];
   logic [63:0] last_load = '0;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          since_rel = 0;
   int          load_fires = 0;
   int          store_fires = 0;
   int          last_load_fire_cyc = 0;
   int          last_store_fire_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
   endtask

   // Monitor: readiness rules, done pulses against the queue, held read data, fire capture.
   always @(negedge clock) begin : monitor
      req_t        h;
      logic [63:0] e;
      logic        exp_rdy;
      int unsigned k;
      if (!reset_n) begin
         chk("reset_load_ready", 64'(opload_index_ready), 64'd0);
         chk("reset_store_ready", 64'(opstore_index_ready), 64'd0);
         chk("reset_dones", 64'({opload_operation_done, opstore_operation_done}), 64'd0);
         chk("reset_read_data", opload_read_data, 64'd0);
         q.delete();
         last_load = '0;
         since_rel = 0;
      end else begin
         if (since_rel >= 1) begin
            exp_rdy = (q.size() == 0);
            chk("load_ready", 64'(opload_index_ready), 64'(exp_rdy));
            chk("store_ready", 64'(opstore_index_ready), 64'(exp_rdy && !opload_index_valid));
         end
         since_rel++;
         if (opload_operation_done && opstore_operation_done) begin
            chk("done_exclusive", 64'b11, 64'b00);
         end
         if (opload_operation_done || opstore_operation_done) begin
            if (q.size() == 0) begin
               chk("spurious_done", 64'({opload_operation_done, opstore_operation_done}), 64'd0);
            end else begin
               h = q.pop_front();
               k = int'(h.idx[DL-1:0]);
               chk("done_kind", 64'({opload_operation_done, opstore_operation_done}),
                   h.ld ? 64'b10 : 64'b01);
               chk("done_latency", 64'(cyc - h.cyc), 64'(LAT));
               if (h.ld) begin
                  e = mdl.exists(k) ? mdl[k] : 64'hx;
                  last_load = e;
               end else begin
                  e = mdl.exists(k) ? mdl[k] : 64'hx;
                  mdl[k] = (e & ~h.mask) | (h.data & h.mask);
               end
            end
         end else if (q.size() > 0 && (cyc - q[0].cyc) > int'(LAT)) begin
            fail_now("done_missing");
            void'(q.pop_front());
         end
         chk("read_data", opload_read_data, last_load);
         if (opload_index_valid && opload_index_ready) begin
            q.push_back('{ld: 1'b1, idx: opload_index, data: '0, mask: '0, cyc: cyc});
            load_fires++;
            last_load_fire_cyc = cyc;
         end
         if (opstore_index_valid && opstore_index_ready) begin
            q.push_back('{ld: 1'b0, idx: opstore_index, data: opstore_write_data,
                          mask: opstore_write_mask, cyc: cyc});
            store_fires++;
            last_store_fire_cyc = cyc;
         end
      end
   end

   // Present requests and drop each valid once it has fired; the other inputs become junk.
   task automatic issue(input bit lv, input bit sv, input logic [63:0] li, input logic [63:0] si,
                        input logic [63:0] sd, input logic [63:0] sm);
      int l0 = load_fires;
      int s0 = store_fires;
      int budget = 0;
      @(posedge clock);
      #1;
      opload_index        = li;
      opstore_index       = si;
      opstore_write_data  = sd;
      opstore_write_mask  = sm;
      opload_index_valid  = lv;
      opstore_index_valid = sv;
      while ((opload_index_valid || opstore_index_valid) && budget < 200) begin
         @(posedge clock);
         #1;
         budget++;
         if (load_fires != l0) begin
            opload_index_valid = 1'b0;
            opload_index       = {$urandom(), $urandom()};
         end
         if (store_fires != s0) begin
            opstore_index_valid = 1'b0;
            opstore_write_data  = {$urandom(), $urandom()};
         end
      end
      if (opload_index_valid || opstore_index_valid) begin
         fail_now("fire_timeout");
         opload_index_valid  = 1'b0;
         opstore_index_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (q.size() != 0 && budget < 100) begin
         @(posedge clock);
         #1;
         budget++;
      end
      if (q.size() != 0) fail_now("idle_timeout");
      @(posedge clock);
      #1;
   endtask

   logic [63:0] li, si, sd, sm, old_word;
   int unsigned sel;

   initial begin
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         issue(1'b0, 1'b1, '0, 64'(i), {$urandom(), $urandom()}, '1);
      end
      wait_idle();

      issue(1'b0, 1'b1, '0, 64'h10, 64'h1122334455667788, '1);
      issue(1'b1, 1'b0, 64'h10, '0, '0, '0);
      wait_idle();
      chk("store_then_load", opload_read_data, 64'h1122334455667788);

      issue(1'b0, 1'b1, '0, 64'd7, '1, '1);
      issue(1'b0, 1'b1, '0, 64'd7, 64'h0000_00AB_0000_0000, 64'h0000_00FF_0000_0000);
      issue(1'b1, 1'b0, 64'd7, '0, '0, '0);
      wait_idle();
      chk("partial_mask", opload_read_data, 64'hFFFF_FFAB_FFFF_FFFF);

      issue(1'b1, 1'b1, 64'd1, 64'd2, 64'h0BAD_F00D_1234_5678, '1);
      wait_idle();
      chk("arb_store_after_load", 64'(last_store_fire_cyc - last_load_fire_cyc), 64'(LAT + 1));

      issue(1'b0, 1'b1, '0, 64'h1005, 64'hA5A5_5A5A_0F0F_F0F0, '1);
      issue(1'b1, 1'b0, 64'h005, '0, '0, '0);
      wait_idle();
      chk("wrap_index", opload_read_data, 64'hA5A5_5A5A_0F0F_F0F0);

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(1, 3);
         li = {$urandom(), $urandom()};
         li[DL-1:0] = DL'($urandom_range(0, 31));
         si = {$urandom(), $urandom()};
         si[DL-1:0] = DL'($urandom_range(0, 31));
         sd = {$urandom(), $urandom()};
         case ($urandom_range(0, 3))
            0:       sm = '0;
            1:       sm = '1;
            2:       sm = 64'hFF << (8 * $urandom_range(0, 7));
            default: sm = {$urandom(), $urandom()};
         endcase
         issue(sel[0], sel[1], li, si, sd, sm);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
      end
      wait_idle();

      old_word = mdl[3];
      issue(1'b0, 1'b1, '0, 64'd3, 64'hDEAD_BEEF_CAFE_F00D, '1);
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clock);
      issue(1'b1, 1'b0, 64'd3, '0, '0, '0);
      wait_idle();
      chk("reset_mid_store", opload_read_data, old_word);

      repeat (3) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
